// File: rtl/rf_wport_arbiter.sv
// Register-file write-port arbiter: WB stage (port A) vs. buffered long-latency port B.
// Optional RF_WPORT_ARB_PEND_MASK_EN adds pend_mask_o listing rd targets queued in the FIFO.
module rf_wport_arbiter #(
    parameter int DEPTH    = 4,
    parameter int MAX_WAIT = 8
) (
    input  logic        clk,
    input  logic        arst_n,
    input  logic        wb_rf_en_i,
    input  logic [4:0]  wb_rd_i,
    input  logic [31:0] wb_data_i,
    output logic        wb_stall_o,
    input  logic        lu_valid_i,
    output logic        lu_ready_o,
    input  logic [4:0]  lu_rd_i,
    input  logic [31:0] lu_wdata_i,
    output logic        rf_we_o,
    output logic [4:0]  rf_waddr_o,
    output logic [31:0] rf_wdata_o
`ifdef RF_WPORT_ARB_PEND_MASK_EN
    ,
    output logic [31:0] pend_mask_o
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int CW = $clog2(MAX_WAIT) + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PEND  = 2'd1,
        FORCE = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [CW-1:0] wait_cnt, wait_nxt;
    logic [4:0]    mem_rd   [DEPTH];
    logic [31:0]   mem_data [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [PW-1:0] wr_ptr_nxt, rd_ptr_nxt;
    logic          full, empty, empty_nxt;
    logic          push, pop;
    logic          a_req, grant_a, grant_b;

    assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty = (wr_ptr == rd_ptr);

    assign lu_ready_o = !full;
    assign push       = lu_valid_i && !full && (lu_rd_i != 5'd0);

    // Gated by reset so the write port is quiet while the arbiter is held.
    assign a_req   = arst_n && wb_rf_en_i && (wb_rd_i != 5'd0);
    assign grant_b = (state == FORCE) || (!a_req && !empty);
    assign grant_a = (state != FORCE) && a_req;
    assign pop     = grant_b;

    assign wr_ptr_nxt = wr_ptr + PW'(push);
    assign rd_ptr_nxt = rd_ptr + PW'(pop);
    assign empty_nxt  = (wr_ptr_nxt == rd_ptr_nxt);

    assign wb_stall_o = (state == FORCE);

    // FIFO payload storage; contents are don't-care until pointed to.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_rd[wr_ptr[AW-1:0]]   <= lu_rd_i;
            mem_data[wr_ptr[AW-1:0]] <= lu_wdata_i;
        end
    end

    // FIFO pointers, arbiter state and starvation counter.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            state    <= IDLE;
            wait_cnt <= '0;
        end else begin
            wr_ptr   <= wr_ptr_nxt;
            rd_ptr   <= rd_ptr_nxt;
            state    <= state_nxt;
            wait_cnt <= wait_nxt;
        end
    end

    // Next state: count ungranted head cycles and force a slot on starvation.
    always_comb begin
        state_nxt = state;
        wait_nxt  = wait_cnt;
        unique case (state)
            IDLE: begin
                wait_nxt = '0;
                if (push) state_nxt = PEND;
            end
            PEND: begin
                if (grant_b) wait_nxt = '0;
                else         wait_nxt = wait_cnt + CW'(1);
                if (!grant_b && wait_cnt == CW'(MAX_WAIT - 1)) begin
                    state_nxt = FORCE;
                    wait_nxt  = '0;
                end else if (empty_nxt) begin
                    state_nxt = IDLE;
                end
            end
            FORCE: begin
                wait_nxt  = '0;
                state_nxt = empty_nxt ? IDLE : PEND;
            end
            default: begin
                state_nxt = IDLE;
                wait_nxt  = '0;
            end
        endcase
    end

    // Drive the register-file write port from the current grant.
    always_comb begin
        rf_we_o    = 1'b0;
        rf_waddr_o = '0;
        rf_wdata_o = '0;
        if (grant_a) begin
            rf_we_o    = 1'b1;
            rf_waddr_o = wb_rd_i;
            rf_wdata_o = wb_data_i;
        end else if (grant_b) begin
            rf_we_o    = 1'b1;
            rf_waddr_o = mem_rd[rd_ptr[AW-1:0]];
            rf_wdata_o = mem_data[rd_ptr[AW-1:0]];
        end
    end

`ifdef RF_WPORT_ARB_PEND_MASK_EN
    logic [PW-1:0] count;

    assign count = wr_ptr - rd_ptr;

    // Mark every queued rd except the head that leaves this cycle.
    always_comb begin
        logic [PW-1:0] idx;
        pend_mask_o = '0;
        idx         = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = rd_ptr + PW'(k);
            if (PW'(k) < count && !(k == 0 && pop))
                pend_mask_o[mem_rd[idx[AW-1:0]]] = 1'b1;
        end
        pend_mask_o[0] = 1'b0;
    end
`endif

endmodule

// File: tb/tb_rf_wport_arbiter.sv
// Scoreboard bench for rf_wport_arbiter: directed stimulus queues expected writes,
// a negedge monitor pops and compares every register-file write.
module tb_rf_wport_arbiter;

    logic        clk = 1'b0;
    logic        arst_n = 1'b0;
    logic        wb_rf_en_i = 1'b0;
    logic [4:0]  wb_rd_i = '0;
    logic [31:0] wb_data_i = '0;
    logic        wb_stall_o;
    logic        lu_valid_i = 1'b0;
    logic        lu_ready_o;
    logic [4:0]  lu_rd_i = '0;
    logic [31:0] lu_wdata_i = '0;
    logic        rf_we_o;
    logic [4:0]  rf_waddr_o;
    logic [31:0] rf_wdata_o;
`ifdef RF_WPORT_ARB_PEND_MASK_EN
    logic [31:0] pend_mask_o;
`endif

    int tests = 0;
    int fails = 0;
    logic [36:0] exp_q[$];

    rf_wport_arbiter #(.DEPTH(4), .MAX_WAIT(8)) dut (
        .clk        (clk),
        .arst_n     (arst_n),
        .wb_rf_en_i (wb_rf_en_i),
        .wb_rd_i    (wb_rd_i),
        .wb_data_i  (wb_data_i),
        .wb_stall_o (wb_stall_o),
        .lu_valid_i (lu_valid_i),
        .lu_ready_o (lu_ready_o),
        .lu_rd_i    (lu_rd_i),
        .lu_wdata_i (lu_wdata_i),
        .rf_we_o    (rf_we_o),
        .rf_waddr_o (rf_waddr_o),
        .rf_wdata_o (rf_wdata_o)
`ifdef RF_WPORT_ARB_PEND_MASK_EN
        ,
        .pend_mask_o(pend_mask_o)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [63:0] act,
                       input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", n, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drv_a(input logic en, input logic [4:0] rd,
                         input logic [31:0] d);
        wb_rf_en_i = en;
        wb_rd_i    = rd;
        wb_data_i  = d;
    endtask

    task automatic drv_b(input logic v, input logic [4:0] rd,
                         input logic [31:0] d);
        lu_valid_i = v;
        lu_rd_i    = rd;
        lu_wdata_i = d;
    endtask

    task automatic exp_w(input logic [4:0] rd, input logic [31:0] d);
        exp_q.push_back({rd, d});
    endtask

    // Monitor: every write must match the oldest queued expectation.
    always @(negedge clk) begin
        if (rf_we_o) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL sb_unexpected: write rd=%0d data=%h, expected none",
                         rf_waddr_o, rf_wdata_o);
            end else begin
                chk("sb_write", {27'd0, rf_waddr_o, rf_wdata_o},
                    {27'd0, exp_q.pop_front()});
            end
        end
    end

    initial begin
        // reset state
        #2;
        chk("rst_we", rf_we_o, 0);
        chk("rst_stall", wb_stall_o, 0);
        chk("rst_ready", lu_ready_o, 1);
        chk("rst_addr", rf_waddr_o, 0);
        chk("rst_data", rf_wdata_o, 0);
        #10 arst_n = 1'b1;
        cyc();
        #2;
        chk("idle_we", rf_we_o, 0);
        chk("idle_ready", lu_ready_o, 1);

        // port B only: written the cycle after acceptance
        cyc();
        drv_b(1, 5'd5, 32'hDEADBEEF);
        exp_w(5'd5, 32'hDEADBEEF);
        #2;
        chk("b_ready", lu_ready_o, 1);
        chk("b_no_we_yet", rf_we_o, 0);
        cyc();
        drv_b(0, 0, 0);
        #2;
        chk("b_we", rf_we_o, 1);
        chk("b_addr", rf_waddr_o, 5);
        chk("b_data", rf_wdata_o, 32'hDEADBEEF);
        chk("b_ready2", lu_ready_o, 1);

        // starvation: A every cycle, one B entry
        cyc();
        drv_a(1, 5'd1, 32'hA000_0000);
        drv_b(1, 5'd9, 32'h0000_900D);
        exp_w(5'd1, 32'hA000_0000);
        for (int i = 1; i <= 8; i++) begin
            cyc();
            drv_b(0, 0, 0);
            drv_a(1, 5'd1, 32'hA000_0000 + i);
            exp_w(5'd1, 32'hA000_0000 + i);
            #2;
            chk("starve_no_stall", wb_stall_o, 0);
        end
        cyc();
        drv_a(1, 5'd1, 32'hA000_0009);
        exp_w(5'd9, 32'h0000_900D);
        #2;
        chk("force_stall", wb_stall_o, 1);
        chk("force_addr", rf_waddr_o, 9);
        cyc();
        exp_w(5'd1, 32'hA000_0009);
        #2;
        chk("held_no_stall", wb_stall_o, 0);
        chk("held_addr", rf_waddr_o, 1);
        cyc();
        drv_a(0, 0, 0);

        // fill FIFO with A busy; full holds off push even on a pop cycle
        for (int c = 0; c <= 8; c++) begin
            cyc();
            drv_a(1, 5'd2, 32'hB000_0000 + c);
            exp_w(5'd2, 32'hB000_0000 + c);
            if (c < 4)
                drv_b(1, 5'(10 + c), 32'hC000_0000 + c);
            else
                drv_b(1, 5'd14, 32'hE000_0014);
            if (c == 4) begin
                #2;
                chk("full_ready", lu_ready_o, 0);
            end
        end
        cyc();
        drv_a(1, 5'd2, 32'hB000_0009);
        exp_w(5'd10, 32'hC000_0000);
        #2;
        chk("full_pop_ready", lu_ready_o, 0);
        chk("full_force", wb_stall_o, 1);
        cyc();
        exp_w(5'd2, 32'hB000_0009);
        #2;
        chk("after_pop_ready", lu_ready_o, 1);
        cyc();
        drv_a(0, 0, 0);
        drv_b(0, 0, 0);
        exp_w(5'd11, 32'hC000_0001);
        cyc();
        exp_w(5'd12, 32'hC000_0002);
        cyc();
        exp_w(5'd13, 32'hC000_0003);
        cyc();
        exp_w(5'd14, 32'hE000_0014);
        cyc();
        #2;
        chk("drained_we", rf_we_o, 0);

        // x0 writeback yields to B; B push to x0 is dropped
        cyc();
        drv_b(1, 5'd2, 32'h0000_0022);
        cyc();
        drv_b(1, 5'd0, 32'h0000_0BAD);
        drv_a(1, 5'd0, 32'h5555_5555);
        exp_w(5'd2, 32'h0000_0022);
        #2;
        chk("x0_ready", lu_ready_o, 1);
        chk("x0_b_addr", rf_waddr_o, 2);
        cyc();
        drv_a(0, 0, 0);
        drv_b(0, 0, 0);
        #2;
        chk("x0_dropped", rf_we_o, 0);
        cyc();
        #2;
        chk("x0_dropped2", rf_we_o, 0);

        // reset with two queued entries discards them
        cyc();
        drv_a(1, 5'd3, 32'hF000_0000);
        drv_b(1, 5'd20, 32'h2020_2020);
        exp_w(5'd3, 32'hF000_0000);
        cyc();
        drv_a(1, 5'd3, 32'hF000_0001);
        drv_b(1, 5'd21, 32'h2121_2121);
        exp_w(5'd3, 32'hF000_0001);
        cyc();
        drv_a(0, 0, 0);
        drv_b(0, 0, 0);
        arst_n = 1'b0;
        #1;
        chk("mid_rst_we", rf_we_o, 0);
        chk("mid_rst_ready", lu_ready_o, 1);
        chk("mid_rst_stall", wb_stall_o, 0);
        #5 arst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cyc();
            #2;
            chk("post_rst_idle", rf_we_o, 0);
        end

`ifdef RF_WPORT_ARB_PEND_MASK_EN
        cyc();
        drv_a(1, 5'd4, 32'h4000_0000);
        drv_b(1, 5'd3, 32'h0000_0033);
        exp_w(5'd4, 32'h4000_0000);
        #2;
        chk("mask_push_excl", pend_mask_o, 0);
        cyc();
        drv_a(1, 5'd4, 32'h4000_0001);
        drv_b(1, 5'd7, 32'h0000_0077);
        exp_w(5'd4, 32'h4000_0001);
        #2;
        chk("mask_one", pend_mask_o, 32'h8);
        cyc();
        drv_a(1, 5'd4, 32'h4000_0002);
        drv_b(0, 0, 0);
        exp_w(5'd4, 32'h4000_0002);
        #2;
        chk("mask_both", pend_mask_o, 32'h88);
        cyc();
        drv_a(0, 0, 0);
        exp_w(5'd3, 32'h0000_0033);
        #2;
        chk("mask_pop3", pend_mask_o, 32'h80);
        cyc();
        exp_w(5'd7, 32'h0000_0077);
        #2;
        chk("mask_pop7", pend_mask_o, 0);
        cyc();
        #2;
        chk("mask_empty", pend_mask_o, 0);
`endif

        cyc();
        cyc();
        chk("sb_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
